cache_fill_ctrl: RTL and testbench
==================================

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: word-address width.
REQ-002 SHALL have parameter DATA_W, default 32: data word width.
REQ-003 SHALL have parameter BURST_LEN, default 4: words per cache line, power of two, minimum 2; LOG_BL = log2(BURST_LEN).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have ports cpu_req (in, 1), cpu_we (in, 1), cpu_addr (in, ADDR_W), cpu_wdata (in, DATA_W): CPU request; held stable until cpu_ready.
REQ-007 SHALL have ports cpu_ready (out, 1) and cpu_rdata (out, DATA_W): one-cycle completion pulse and read data.
REQ-008 SHALL have ports hit (in, 1) and cache_rdata (in, DATA_W): cache tag-compare result and hit data for cpu_addr, combinational from the cache.
REQ-009 SHALL have ports cache_we (out, 1), cache_addr (out, ADDR_W), cache_wdata (out, DATA_W): cache word write for line fill or write-hit update.
REQ-010 SHALL have port cache_fill_done (out, 1): one-cycle pulse; cache sets tag/valid for line cpu_addr>>LOG_BL.
REQ-011 SHALL have ports mem_read (out, 1), mem_write (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, DATA_W), mem_rdata (in, DATA_W): backing memory; read data valid exactly one cycle after mem_read.
REQ-012 SHALL have port busy (out, 1): high in every state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, HIT_RD, FILL, FILL_END, RESPOND, WRITE.
REQ-014 In IDLE with cpu_req=1, SHALL go to WRITE if cpu_we=1; HIT_RD if cpu_we=0 and hit=1; FILL if cpu_we=0 and hit=0.
REQ-015 HIT_RD SHALL last one cycle: cpu_ready=1 and cpu_rdata = cache_rdata registered on acceptance; read-hit latency 1 cycle after acceptance.
REQ-016 In FILL, SHALL assert mem_read on BURST_LEN consecutive cycles, with mem_addr = line base (cpu_addr, low LOG_BL bits cleared) plus a LOG_BL-bit beat offset.
REQ-017 Each cycle after a mem_read beat, SHALL assert cache_we with cache_addr = that beat's address and cache_wdata = mem_rdata.
REQ-018 SHALL capture into cpu_rdata the beat whose offset equals cpu_addr[LOG_BL-1:0].
REQ-019 FILL_END SHALL write the last beat and pulse cache_fill_done, then go to RESPOND.
REQ-020 RESPOND SHALL pulse cpu_ready with captured data, then go to IDLE; read-miss latency is BURST_LEN+2 cycles after acceptance.
REQ-021 WRITE SHALL last one cycle: write-through, no write-allocate; mem_write=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, cpu_ready=1.
REQ-022 In WRITE, SHALL assert cache_we to cpu_addr with cpu_wdata only if hit was 1 at acceptance.
REQ-023 SHALL ignore cpu_req while busy=1; a request accepted in IDLE SHALL be followed by at most one cpu_ready.
REQ-024 Beat offset SHALL wrap modulo BURST_LEN; mem_addr SHALL never leave the requested line.
REQ-025 Back-to-back requests SHALL be accepted no earlier than the cycle after cpu_ready.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, enter IDLE and clear cpu_ready, cpu_rdata, cache_we, cache_fill_done, mem_read, mem_write, busy, and the beat counters.
REQ-027 SHALL treat reset mid-fill as an abort: no further mem_read, cache_we, cache_fill_done or cpu_ready from the aborted request.
REQ-028 SHALL keep all outputs stable at reset values from the first clock edge with rst=1.

Configuration
REQ-029 With CACHE_FILL_CRITICAL_FIRST_EN defined, SHALL start the burst at offset cpu_addr[LOG_BL-1:0] and wrap, and SHALL go to RESPOND in the cycle after beat 0 returns, overlapping the remaining writes; read-miss latency is 2 cycles.
REQ-030 In that mode, FILL SHALL continue after cpu_ready and keep busy=1 until cache_fill_done.
REQ-031 Without CACHE_FILL_CRITICAL_FIRST_EN, SHALL start every burst at offset 0 per REQ-016 to REQ-020.

Verification
REQ-032 rst for 2 cycles mid-FILL -> next cycle all outputs 0, state IDLE, no cache_fill_done.
REQ-033 Read hit, cpu_addr=0x10, cache_rdata=0xAB -> cpu_ready 1 cycle later, cpu_rdata=0xAB, no mem_read.
REQ-034 Read miss, cpu_addr=0x26, BURST_LEN=4, no macro -> mem_addr 0x24,0x25,0x26,0x27; 4 cache_we; cache_fill_done; cpu_ready at cycle 6, cpu_rdata = mem word 0x26.
REQ-035 Same miss with CACHE_FILL_CRITICAL_FIRST_EN -> mem_addr 0x26,0x27,0x24,0x25; cpu_ready at cycle 2; busy held until cache_fill_done.
REQ-036 Write, cpu_addr=0x08, wdata=0x55: hit=1 -> mem_write and cache_we in one cycle; hit=0 -> mem_write only.
REQ-037 cpu_req toggled during FILL -> no extra acceptance; exactly one cpu_ready per accepted request.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: read/write controller sitting between a CPU port, a
// direct cache data array and a backing memory.
//  - read hit  : data returned one cycle after acceptance
//  - read miss : line filled with a BURST_LEN-beat memory burst, then answered
//  - write     : write-through, no write-allocate (cache updated only on hit)
// Optional build macro CACHE_FILL_CRITICAL_FIRST_EN: the burst starts at the
// requested word, the CPU is answered as soon as that word returns, and the
// remaining beats of the line are filled in the background (busy stays high).
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for cpu_req; only state in which requests are taken
// HIT_RD    | read hit, cpu_ready with data registered at acceptance
// FILL      | issuing memory read beats, writing returned beats to cache
// FILL_END  | writing the last beat, pulsing cache_fill_done
// RESPOND   | cpu_ready for a read miss (also issues a beat in critical-first)
// WRITE     | write-through to memory, cache update if hit at acceptance
module cache_fill_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              hit,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              cache_we,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              cache_fill_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LOG_BL = $clog2(BURST_LEN);

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
  localparam bit CRIT_FIRST = 1'b1;
`else
  localparam bit CRIT_FIRST = 1'b0;
`endif

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HIT_RD   = 3'd1;
  localparam logic [2:0] S_FILL     = 3'd2;
  localparam logic [2:0] S_FILL_END = 3'd3;
  localparam logic [2:0] S_RESPOND  = 3'd4;
  localparam logic [2:0] S_WRITE    = 3'd5;

  localparam logic [LOG_BL-1:0] LAST_BEAT = LOG_BL'(BURST_LEN - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hit_q, hit_d;
  logic [LOG_BL-1:0] off_q, off_d;     // offset of the next beat to issue (wraps)
  logic [LOG_BL-1:0] left_q, left_d;   // beats remaining after the next one
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_vld_q;         // a beat's data is on mem_rdata this cycle
  logic [ADDR_W-1:0] wr_addr_q;        // address of that beat

  logic              rd_issue;
  logic              wr_hit;
  logic              beat_match;
  logic [ADDR_W-1:0] beat_addr;

  // Beat address stays inside the line latched at acceptance
  assign beat_addr  = {addr_q[ADDR_W-1:LOG_BL], off_q};
  assign rd_issue   = (state_q == S_FILL) || (CRIT_FIRST && (state_q == S_RESPOND));
  assign wr_hit     = (state_q == S_WRITE) && hit_q;
  assign beat_match = wr_vld_q && (wr_addr_q[LOG_BL-1:0] == addr_q[LOG_BL-1:0]);

  // Next-state, burst counters and read-data capture
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hit_d   = hit_q;
    off_d   = off_q;
    left_d  = left_q;
    rdata_d = rdata_q;

    if (beat_match) begin
      rdata_d = mem_rdata;
    end

    if (rd_issue) begin
      off_d  = off_q + LOG_BL'(1);
      left_d = left_q - LOG_BL'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d = cpu_addr;
          hit_d  = hit;
          if (cpu_we) begin
            state_d = S_WRITE;
          end else if (hit) begin
            rdata_d = cache_rdata;
            state_d = S_HIT_RD;
          end else begin
            state_d = S_FILL;
            left_d  = LAST_BEAT;
            off_d   = CRIT_FIRST ? cpu_addr[LOG_BL-1:0] : '0;
          end
        end
      end
      S_HIT_RD: state_d = S_IDLE;
      S_FILL: begin
        if (CRIT_FIRST && (left_q == LAST_BEAT)) begin
          state_d = S_RESPOND;
        end else if (left_q == '0) begin
          state_d = S_FILL_END;
        end
      end
      S_FILL_END: state_d = CRIT_FIRST ? S_IDLE : S_RESPOND;
      S_RESPOND: begin
        if (CRIT_FIRST) begin
          state_d = (left_q == '0) ? S_FILL_END : S_FILL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      hit_q     <= 1'b0;
      off_q     <= '0;
      left_q    <= '0;
      rdata_q   <= '0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      hit_q     <= hit_d;
      off_q     <= off_d;
      left_q    <= left_d;
      rdata_q   <= rdata_d;
      wr_vld_q  <= rd_issue;
      wr_addr_q <= beat_addr;
    end
  end

  // Outputs; address/data buses are zero when their strobe is low
  always_comb begin
    cpu_ready       = (state_q == S_HIT_RD) || (state_q == S_RESPOND) || (state_q == S_WRITE);
    // In critical-first the requested word arrives during RESPOND itself
    cpu_rdata       = ((state_q == S_RESPOND) && beat_match) ? mem_rdata : rdata_q;
    cache_fill_done = (state_q == S_FILL_END);
    busy            = (state_q != S_IDLE);
    mem_read        = rd_issue;
    mem_write       = (state_q == S_WRITE);
    mem_addr        = rd_issue ? beat_addr : (mem_write ? addr_q : '0);
    mem_wdata       = mem_write ? cpu_wdata : '0;
    cache_we        = wr_vld_q || wr_hit;
    cache_addr      = wr_vld_q ? wr_addr_q : (wr_hit ? addr_q : '0);
    cache_wdata     = wr_vld_q ? mem_rdata : (wr_hit ? cpu_wdata : '0);
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed testbench for cache_fill_ctrl in its default build (BURST_LEN=4).
module tb_cache_fill_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  logic          hit;
  logic [DW-1:0] cache_rdata;
  logic          cache_we;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_wdata;
  logic          cache_fill_done;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int total = 0;
  int bad   = 0;

  cache_fill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .hit(hit), .cache_rdata(cache_rdata),
    .cache_we(cache_we), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_fill_done(cache_fill_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Backing memory: read data one cycle after mem_read
  always @(posedge clk) mem_rdata <= mem_read ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    hit = 1'b0; cache_rdata = '0;
  endtask

  task automatic test_reset;
    logic [5:0] strobes;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    strobes = {busy, cpu_ready, cache_we, cache_fill_done, mem_read, mem_write};
    total++;
    if (strobes !== 6'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=000000", strobes);
    end
    total++;
    if (cpu_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata got=%h want=0", cpu_rdata);
    end
    total++;
    if ({mem_addr, cache_addr} !== 64'h0) begin
      bad++; $display("FAIL reset_addr got mem=%h cache=%h want=0", mem_addr, cache_addr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_hit;
    cpu_addr = 32'h10; cpu_we = 1'b0; hit = 1'b1; cache_rdata = 32'hAB; cpu_req = 1'b1;
    tick();
    total++;
    if (cpu_ready !== 1'b1) begin
      bad++; $display("FAIL hit_ready got=%b want=1", cpu_ready);
    end
    total++;
    if (cpu_rdata !== 32'hAB) begin
      bad++; $display("FAIL hit_rdata got=%h want=ab", cpu_rdata);
    end
    total++;
    if (mem_read !== 1'b0) begin
      bad++; $display("FAIL hit_no_memread got=%b want=0", mem_read);
    end
    idle_inputs();
    tick();
    total++;
    if ({cpu_ready, busy} !== 2'b00) begin
      bad++; $display("FAIL hit_after got ready/busy=%b want=00", {cpu_ready, busy});
    end
  endtask

  task automatic test_read_miss;
    logic [31:0] ea;
    cpu_addr = 32'h26; cpu_we = 1'b0; hit = 1'b0; cpu_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      total++;
      if (mem_read !== (c >= 1 && c <= 4)) begin
        bad++; $display("FAIL miss_memread c=%0d got=%b want=%b", c, mem_read, (c >= 1 && c <= 4));
      end
      if (c >= 1 && c <= 4) begin
        ea = 32'h24 + 32'(c - 1);
        total++;
        if (mem_addr !== ea) begin
          bad++; $display("FAIL miss_memaddr c=%0d got=%h want=%h", c, mem_addr, ea);
        end
      end
      total++;
      if (cache_we !== (c >= 2 && c <= 5)) begin
        bad++; $display("FAIL miss_cachewe c=%0d got=%b want=%b", c, cache_we, (c >= 2 && c <= 5));
      end
      if (c >= 2 && c <= 5) begin
        ea = 32'h24 + 32'(c - 2);
        total++;
        if ({cache_addr, cache_wdata} !== {ea, mem_word(ea)}) begin
          bad++; $display("FAIL miss_cachewr c=%0d got=%h/%h want=%h/%h", c, cache_addr, cache_wdata, ea, mem_word(ea));
        end
      end
      total++;
      if (cache_fill_done !== (c == 5)) begin
        bad++; $display("FAIL miss_done c=%0d got=%b want=%b", c, cache_fill_done, (c == 5));
      end
      total++;
      if (cpu_ready !== (c == 6)) begin
        bad++; $display("FAIL miss_ready c=%0d got=%b want=%b", c, cpu_ready, (c == 6));
      end
      total++;
      if (busy !== (c <= 6)) begin
        bad++; $display("FAIL miss_busy c=%0d got=%b want=%b", c, busy, (c <= 6));
      end
      if (c == 6) begin
        total++;
        if (cpu_rdata !== mem_word(32'h26)) begin
          bad++; $display("FAIL miss_rdata got=%h want=%h", cpu_rdata, mem_word(32'h26));
        end
        idle_inputs();
      end
    end
  endtask

  task automatic test_req_toggle;
    int n_ready, n_read;
    logic seen;
    logic [31:0] rd_at_ready;
    n_ready = 0; n_read = 0; seen = 1'b0; rd_at_ready = '0;
    cpu_addr = 32'h41; cpu_we = 1'b0; hit = 1'b0; cpu_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (mem_read === 1'b1) n_read++;
      if (cpu_ready === 1'b1) begin
        n_ready++;
        seen = 1'b1;
        rd_at_ready = cpu_rdata;
      end
      cpu_req = seen ? 1'b0 : ~cpu_req;
    end
    total++;
    if (n_ready !== 1) begin
      bad++; $display("FAIL toggle_ready_count got=%0d want=1", n_ready);
    end
    total++;
    if (n_read !== BL) begin
      bad++; $display("FAIL toggle_read_count got=%0d want=%0d", n_read, BL);
    end
    total++;
    if (rd_at_ready !== mem_word(32'h41)) begin
      bad++; $display("FAIL toggle_rdata got=%h want=%h", rd_at_ready, mem_word(32'h41));
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL toggle_idle got busy=%b want=0", busy);
    end
    idle_inputs();
  endtask

  task automatic test_write(input logic h);
    cpu_addr = 32'h08; cpu_wdata = 32'h55; cpu_we = 1'b1; hit = h; cpu_req = 1'b1;
    tick();
    hit = ~h;
    total++;
    if ({mem_write, cpu_ready, mem_read} !== 3'b110) begin
      bad++; $display("FAIL wr_strobes hit=%b got=%b want=110", h, {mem_write, cpu_ready, mem_read});
    end
    total++;
    if ({mem_addr, mem_wdata} !== {32'h08, 32'h55}) begin
      bad++; $display("FAIL wr_mem hit=%b got=%h/%h want=8/55", h, mem_addr, mem_wdata);
    end
    total++;
    if (cache_we !== h) begin
      bad++; $display("FAIL wr_cachewe hit=%b got=%b want=%b", h, cache_we, h);
    end
    if (h) begin
      total++;
      if ({cache_addr, cache_wdata} !== {32'h08, 32'h55}) begin
        bad++; $display("FAIL wr_cachedata got=%h/%h want=8/55", cache_addr, cache_wdata);
      end
    end
    idle_inputs();
    tick();
    total++;
    if ({mem_write, cache_we, busy} !== 3'b000) begin
      bad++; $display("FAIL wr_after hit=%b got=%b want=000", h, {mem_write, cache_we, busy});
    end
  endtask

  task automatic test_back_to_back;
    cpu_addr = 32'h10; cpu_we = 1'b0; hit = 1'b1; cache_rdata = 32'hAB; cpu_req = 1'b1;
    tick();
    total++;
    if (cpu_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_first_ready got=%b want=1", cpu_ready);
    end
    cpu_addr = 32'h14; cache_rdata = 32'hCD;
    tick();
    total++;
    if ({cpu_ready, busy} !== 2'b00) begin
      bad++; $display("FAIL b2b_gap got ready/busy=%b want=00", {cpu_ready, busy});
    end
    tick();
    total++;
    if ({cpu_ready, cpu_rdata} !== {1'b1, 32'hCD}) begin
      bad++; $display("FAIL b2b_second got=%b/%h want=1/cd", cpu_ready, cpu_rdata);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_fill;
    logic [5:0] strobes;
    int n_act;
    cpu_addr = 32'h30; cpu_we = 1'b0; hit = 1'b0; cpu_req = 1'b1;
    tick();
    tick();
    total++;
    if (mem_read !== 1'b1) begin
      bad++; $display("FAIL abort_setup got mem_read=%b want=1", mem_read);
    end
    idle_inputs();
    rst = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      strobes = {busy, cpu_ready, cache_we, cache_fill_done, mem_read, mem_write};
      total++;
      if (strobes !== 6'b0) begin
        bad++; $display("FAIL abort_reset_strobes c=%0d got=%b want=000000", c, strobes);
      end
      total++;
      if ({cpu_rdata, mem_addr, cache_addr, cache_wdata} !== 128'h0) begin
        bad++; $display("FAIL abort_reset_buses c=%0d got rdata=%h maddr=%h caddr=%h cwd=%h want=0",
                        c, cpu_rdata, mem_addr, cache_addr, cache_wdata);
      end
    end
    rst = 1'b0;
    n_act = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if ({busy, cpu_ready, cache_we, cache_fill_done, mem_read} !== 5'b0) n_act++;
    end
    total++;
    if (n_act !== 0) begin
      bad++; $display("FAIL abort_after active_cycles=%0d want=0", n_act);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_read_hit();
    test_read_miss();
    test_req_toggle();
    test_write(1'b1);
    test_write(1'b0);
    test_back_to_back();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
